regfile_mp: RTL and testbench

- Parametrised multi-port integer register file for LemonPC; successor to the single-write, dual-read register file.
- Provides NR combinational read ports and NW synchronous write ports, with optional same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard: decode sets busy for a pending producer, writeback clears it.
- Register 0 is hardwired to zero and is never busy.

---
 rtl/regfile_mp_if.sv | 32 +++
 rtl/regfile_mp.sv | 114 +++++++++++
 tb/tb_regfile_mp.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bundles the read, write and scoreboard signals of regfile_mp.
// The master side (core pipeline) drives addresses, write data, alloc and flush;
// the slave side (register file) returns read data, busy bits and the busy vector.
interface regfile_mp_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 64,
   parameter int NR         = 2,
   parameter int NW         = 1
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [NR*ADDR_WIDTH-1:0] rd_addr;
   logic [NR*DATA_WIDTH-1:0] rd_data;
   logic [NR-1:0]            rd_busy;
   logic [NW-1:0]            wr_en;
   logic [NW*ADDR_WIDTH-1:0] wr_addr;
   logic [NW*DATA_WIDTH-1:0] wr_data;
   logic                     alloc_en;
   logic [ADDR_WIDTH-1:0]    alloc_addr;
   logic                     flush;
   logic [DEPTH-1:0]         busy_vec;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
      input  rd_data, rd_busy, busy_vec
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
      output rd_data, rd_busy, busy_vec
   );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a per-register busy scoreboard.
// NR combinational read ports, NW synchronous write ports, x0 hardwired to zero.
// BYPASS=1 forwards same-cycle write data to matching reads (highest write port wins).
// Optional macro REGFILE_TRACE_EN adds a simulation-only change trace; when it is
// undefined the module contains no trace logic at all.
module regfile_mp #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 64,
   parameter int NR         = 2,
   parameter int NW         = 1,
   parameter int BYPASS     = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   regfile_mp_if.slave     bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] rf_q [DEPTH];
   logic [DATA_WIDTH-1:0] rf_d [DEPTH];
   logic [DEPTH-1:0]      busy_q;
   logic [DEPTH-1:0]      busy_d;

   // Next-state for storage and scoreboard; later ports override earlier ones,
   // so the highest-index write port wins an address conflict.
   always_comb begin
      logic [ADDR_WIDTH-1:0] wa;
      for (int i = 0; i < DEPTH; i++) begin
         rf_d[i] = rf_q[i];
      end
      busy_d = busy_q;
      wa     = '0;
      for (int j = 0; j < NW; j++) begin
         wa = bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
         if (bus.wr_en[j]) begin
            if (wa != '0) begin
               rf_d[wa] = bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
            busy_d[wa] = 1'b0;
         end
      end
      // A new producer supersedes the one retiring in the same cycle.
      if (bus.alloc_en) begin
         busy_d[bus.alloc_addr] = 1'b1;
      end
      if (bus.flush) begin
         busy_d = '0;
      end
      busy_d[0] = 1'b0;
   end

   // State registers; synchronous active-low reset clears data and scoreboard.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            rf_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            rf_q[i] <= rf_d[i];
         end
         busy_q <= busy_d;
      end
   end

   assign bus.busy_vec = busy_q;

   for (genvar k = 0; k < NR; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] rd_val;

      assign ra = bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

      // Read mux: stored value, optionally forwarded from a same-cycle write; x0 reads zero.
      always_comb begin
         rd_val = rf_q[ra];
         if (BYPASS != 0) begin
            for (int j = 0; j < NW; j++) begin
               if (bus.wr_en[j] && (bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
                  rd_val = bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end
         if (ra == '0) begin
            rd_val = '0;
         end
      end

      assign bus.rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_val;
      // Busy reflects registered state only, never the same-cycle update.
      assign bus.rd_busy[k] = busy_q[ra];
   end

`ifdef REGFILE_TRACE_EN
   // Simulation-only trace of register changes, flush and alloc events.
   always @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (rf_d[i] != rf_q[i]) begin
               $display("x%0d: 0x%0x -> 0x%0x", i, rf_q[i], rf_d[i]);
            end
         end
         if (bus.flush) begin
            $display("flush: busy 0x%0x -> 0x0", busy_q);
         end
         if (bus.alloc_en) begin
            $display("alloc: x%0d", bus.alloc_addr);
         end
      end
   end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for regfile_mp.
// Instance A: NR=2, NW=1, BYPASS=0. Instance B: NR=2, NW=2, BYPASS=1.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_regfile_mp;
   localparam int AW = 5;
   localparam int DW = 64;

   logic clk;
   logic rst_n;

   regfile_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR(2), .NW(1)) ia ();
   regfile_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR(2), .NW(2)) ib ();

   regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR(2), .NW(1), .BYPASS(0)) u_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ia)
   );

   regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR(2), .NW(2), .BYPASS(1)) u_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ib)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // kind: 0 = rd_data[idx], 1 = rd_busy[idx], 2 = busy_vec
   typedef struct {
      string       name;
      int          dut;
      int          kind;
      int          idx;
      logic [63:0] exp;
   } exp_t;

   exp_t sbq[$];
   int   tests  = 0;
   int   failed = 0;

   function automatic logic [63:0] act_of(exp_t e);
      logic [63:0] v;
      v = '0;
      if (e.dut == 0) begin
         case (e.kind)
            0:       v = ia.rd_data[e.idx*DW +: DW];
            1:       v = {63'd0, ia.rd_busy[e.idx]};
            default: v = {32'd0, ia.busy_vec};
         endcase
      end else begin
         case (e.kind)
            0:       v = ib.rd_data[e.idx*DW +: DW];
            1:       v = {63'd0, ib.rd_busy[e.idx]};
            default: v = {32'd0, ib.busy_vec};
         endcase
      end
      return v;
   endfunction

   // Monitor: compare every pending expectation while outputs are stable.
   always @(negedge clk) begin
      while (sbq.size() > 0) begin
         exp_t e;
         logic [63:0] a;
         e = sbq.pop_front();
         a = act_of(e);
         tests = tests + 1;
         if (a !== e.exp) begin
            failed = failed + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, a, e.exp);
         end
      end
   end

   task automatic push(string n, int dut, int kind, int idx, logic [63:0] v);
      exp_t e;
      e.name = n; e.dut = dut; e.kind = kind; e.idx = idx; e.exp = v;
      sbq.push_back(e);
   endtask

   task automatic idle();
      ia.rd_addr = '0; ia.wr_en = '0; ia.wr_addr = '0; ia.wr_data = '0;
      ia.alloc_en = 1'b0; ia.alloc_addr = '0; ia.flush = 1'b0;
      ib.rd_addr = '0; ib.wr_en = '0; ib.wr_addr = '0; ib.wr_data = '0;
      ib.alloc_en = 1'b0; ib.alloc_addr = '0; ib.flush = 1'b0;
   endtask

   // Start a new cycle: just after the edge, inputs back to idle, reset released.
   task automatic cyc();
      @(posedge clk);
      #1;
      idle();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      repeat (2) @(posedge clk);

      // Post-reset state
      cyc();
      ia.rd_addr = {5'd7, 5'd5};
      push("reset_rd_x5", 0, 0, 0, 64'h0);
      push("reset_busy_x7", 0, 1, 1, 64'h0);
      push("reset_vec_a", 0, 2, 0, 64'h0);
      push("reset_vec_b", 1, 2, 0, 64'h0);

      // Write x5, alloc x7, then reset with them in place
      cyc();
      ia.wr_en = 1'b1; ia.wr_addr = 5'd5; ia.wr_data = 64'h1234;
      ia.alloc_en = 1'b1; ia.alloc_addr = 5'd7;
      cyc();
      ia.rd_addr = {5'd7, 5'd5};
      push("pre_reset_rd_x5", 0, 0, 0, 64'h1234);
      push("pre_reset_busy_x7", 0, 1, 1, 64'h1);
      rst_n = 1'b0;
      ia.wr_en = 1'b1; ia.wr_addr = 5'd5; ia.wr_data = 64'h9999;
      ia.alloc_en = 1'b1; ia.alloc_addr = 5'd8;
      cyc();
      ia.rd_addr = {5'd7, 5'd5};
      push("after_reset_rd_x5", 0, 0, 0, 64'h0);
      push("after_reset_busy_x7", 0, 1, 1, 64'h0);
      push("after_reset_vec", 0, 2, 0, 64'h0);

      // Basic write: A holds old value in write cycle, B forwards
      cyc();
      ia.wr_en = 1'b1; ia.wr_addr = 5'd3; ia.wr_data = 64'hDEADBEEF; ia.rd_addr = {5'd0, 5'd3};
      ib.wr_en = 2'b01; ib.wr_addr = {5'd0, 5'd3}; ib.wr_data = {64'd0, 64'hDEADBEEF};
      ib.rd_addr = {5'd3, 5'd3};
      push("nobyp_old_x3", 0, 0, 0, 64'h0);
      push("byp_fwd_x3", 1, 0, 0, 64'hDEADBEEF);
      cyc();
      ia.rd_addr = {5'd3, 5'd3};
      push("nobyp_new_x3_p0", 0, 0, 0, 64'hDEADBEEF);
      push("nobyp_new_x3_p1", 0, 0, 1, 64'hDEADBEEF);

      // Write conflict on B: highest port wins for bypass and storage
      cyc();
      ib.wr_en = 2'b11; ib.wr_addr = {5'd4, 5'd4}; ib.wr_data = {64'h22, 64'h11};
      ib.rd_addr = {5'd4, 5'd4};
      push("conflict_byp_p0", 1, 0, 0, 64'h22);
      push("conflict_byp_p1", 1, 0, 1, 64'h22);
      cyc();
      ib.rd_addr = {5'd3, 5'd4};
      push("conflict_stored", 1, 0, 0, 64'h22);
      push("byp_stored_x3", 1, 0, 1, 64'hDEADBEEF);

      // x0 guard on both instances
      cyc();
      ia.wr_en = 1'b1; ia.wr_addr = 5'd0; ia.wr_data = 64'hFFFF;
      ia.alloc_en = 1'b1; ia.alloc_addr = 5'd0;
      ib.wr_en = 2'b10; ib.wr_addr = {5'd0, 5'd0}; ib.wr_data = {64'hFFFF, 64'd0};
      ib.rd_addr = {5'd0, 5'd0};
      push("x0_byp_zero", 1, 0, 0, 64'h0);
      cyc();
      ia.rd_addr = {5'd0, 5'd0};
      ib.rd_addr = {5'd0, 5'd0};
      push("x0_rd_a", 0, 0, 0, 64'h0);
      push("x0_busy_a", 0, 1, 0, 64'h0);
      push("x0_vec_a", 0, 2, 0, 64'h0);
      push("x0_rd_b", 1, 0, 1, 64'h0);

      // Scoreboard: alloc, retire, simultaneous alloc+write
      cyc();
      ia.alloc_en = 1'b1; ia.alloc_addr = 5'd9; ia.rd_addr = {5'd9, 5'd0};
      push("alloc_not_yet", 0, 1, 1, 64'h0);
      cyc();
      ia.rd_addr = {5'd9, 5'd0};
      push("alloc_busy", 0, 1, 1, 64'h1);
      push("alloc_vec", 0, 2, 0, 64'h200);
      ia.wr_en = 1'b1; ia.wr_addr = 5'd9; ia.wr_data = 64'h5;
      cyc();
      ia.rd_addr = {5'd9, 5'd0};
      push("retire_busy", 0, 1, 1, 64'h0);
      push("retire_data", 0, 0, 1, 64'h5);
      ia.wr_en = 1'b1; ia.wr_addr = 5'd9; ia.wr_data = 64'h77;
      ia.alloc_en = 1'b1; ia.alloc_addr = 5'd9;
      cyc();
      ia.rd_addr = {5'd9, 5'd0};
      push("alloc_wins_busy", 0, 1, 1, 64'h1);
      push("alloc_wins_data", 0, 0, 1, 64'h77);
      push("alloc_wins_vec", 0, 2, 0, 64'h200);

      // Flush after three allocs, with a same-cycle alloc; B retires on port 1
      ia.alloc_en = 1'b1; ia.alloc_addr = 5'd1;
      ib.alloc_en = 1'b1; ib.alloc_addr = 5'd6;
      cyc();
      ia.alloc_en = 1'b1; ia.alloc_addr = 5'd2;
      push("b_alloc_vec", 1, 2, 0, 64'h40);
      ib.wr_en = 2'b10; ib.wr_addr = {5'd6, 5'd0}; ib.wr_data = {64'hAB, 64'd0};
      cyc();
      ia.alloc_en = 1'b1; ia.alloc_addr = 5'd3;
      ib.rd_addr = {5'd6, 5'd0};
      push("b_retire_vec", 1, 2, 0, 64'h0);
      push("b_retire_data", 1, 0, 1, 64'hAB);
      cyc();
      push("pre_flush_vec", 0, 2, 0, 64'h20E);
      ia.flush = 1'b1; ia.alloc_en = 1'b1; ia.alloc_addr = 5'd4;
      cyc();
      ia.rd_addr = {5'd4, 5'd9};
      push("flush_vec", 0, 2, 0, 64'h0);
      push("flush_busy_x4", 0, 1, 1, 64'h0);
      push("flush_keeps_data", 0, 0, 0, 64'h77);

      // Drain with a bounded wait
      for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
      if (sbq.size() > 0) begin
         failed = failed + 1;
         $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
      end
      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
